// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing constants.
//   CLK_HZ       - nominal system clock frequency (CLOCK_50)
//   BAUD_9600,
//   BAUD_115200  - standard line rates
//   calc_div()   - clock cycles per oversample tick, rounded to nearest
package uart_pkg;

    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned BAUD_9600   = 9_600;
    localparam int unsigned BAUD_115200 = 115_200;

    // Rounded divisor: clk_hz / (baud * os), half-up.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned period;
        period = baud * os;
        return (clk_hz + period / 2) / period;
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// mod_n_counter: loadable modulo counter.
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, count returns to 0
//   en       - advance the count by one
//   load     - overrides en; count takes load_val
//   load_val - value taken on load
//   last     - terminal value; the count after it is 0 (modulus = last + 1)
//   count    - current count
//   wrap     - combinational, high when an enabled edge will wrap last -> 0
module mod_n_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Explicit compare against last so non-power-of-two moduli wrap correctly.
    assign wrap = en && (count_reg == last);

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (en) begin
            count_next = wrap ? '0 : count_reg + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: runtime-programmable baud tick generator with oversampling.
//   CLOCK_50 - system clock, rising edge
//   rst      - synchronous active-high reset
//   en       - count enable; counters hold while low
//   div_i    - divisor (clock cycles per oversample tick) for div_load
//   div_load - strobe: take div_i, restart the bit
//   align    - strobe: restart the phase at half a bit (RX mid-bit sampling)
//   tick_os  - one-cycle pulse per oversample period
//   tick_bit - one-cycle pulse per bit period, coincident with a tick_os
//   os_phase - oversample index within the bit, 0..OS-1
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = uart_pkg::CLK_HZ,
    parameter int DIV_W       = 16,
    parameter int OS          = 16,
    parameter int DEFAULT_DIV = int'(uart_pkg::calc_div(CLK_HZ, BAUD_115200, OS))
) (
    input  logic                  CLOCK_50,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DIV_W-1:0]      div_i,
    input  logic                  div_load,
    input  logic                  align,
    output logic                  tick_os,
    output logic                  tick_bit,
    output logic [$clog2(OS)-1:0] os_phase
);

    localparam int PH_W = $clog2(OS);
    localparam logic [PH_W-1:0] OS_LAST = PH_W'(OS - 1);
    localparam logic [PH_W-1:0] OS_HALF = PH_W'(OS / 2);

    logic [DIV_W-1:0] div_q_reg;
    logic [DIV_W-1:0] div_q_next;
    logic             tick_os_reg;
    logic             tick_os_next;
    logic             tick_bit_reg;
    logic             tick_bit_next;

    logic             active;
    logic             restart;
    logic [DIV_W-1:0] div_last;
    logic [DIV_W-1:0] cnt_q;
    logic             cnt_wrap;
    logic [PH_W-1:0]  os_q;
    logic             os_wrap;

    // A zero divisor parks the generator exactly like en=0.
    assign active   = en && (div_q_reg != '0);
    assign restart  = align || div_load;
    assign div_last = div_q_reg - DIV_W'(1);

    mod_n_counter #(
        .W (DIV_W)
    ) u_cnt (
        .clk      (CLOCK_50),
        .rst      (rst),
        .en       (active),
        .load     (restart),
        .load_val ('0),
        .last     (div_last),
        .count    (cnt_q),
        .wrap     (cnt_wrap)
    );

    // The oversample counter steps once per divisor wrap; align parks it at
    // mid-bit so the first tick_bit lands half a bit later.
    mod_n_counter #(
        .W (PH_W)
    ) u_os (
        .clk      (CLOCK_50),
        .rst      (rst),
        .en       (cnt_wrap),
        .load     (restart),
        .load_val (align ? OS_HALF : '0),
        .last     (OS_LAST),
        .count    (os_q),
        .wrap     (os_wrap)
    );

    always_comb begin
        div_q_next = div_q_reg;
        // align takes priority, so div_i is ignored when both strobe.
        if (!align && div_load) begin
            div_q_next = div_i;
        end
    end

    // Pulses are suppressed on any restart edge; the new phase starts clean.
    assign tick_os_next  = active && !restart && (cnt_q == div_last);
    assign tick_bit_next = tick_os_next && os_wrap;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            div_q_reg    <= DIV_W'(DEFAULT_DIV);
            tick_os_reg  <= 1'b0;
            tick_bit_reg <= 1'b0;
        end else begin
            div_q_reg    <= div_q_next;
            tick_os_reg  <= tick_os_next;
            tick_bit_reg <= tick_bit_next;
        end
    end

    assign tick_os  = tick_os_reg;
    assign tick_bit = tick_bit_reg;
    assign os_phase = os_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
module tb_uart_baud_gen;

    localparam int OS    = 16;
    localparam int DIV_W = 16;
    localparam int DEF   = 27;

    logic             CLOCK_50 = 1'b0;
    logic             rst      = 1'b1;
    logic             en       = 1'b0;
    logic [DIV_W-1:0] div_i    = '0;
    logic             div_load = 1'b0;
    logic             align    = 1'b0;
    logic             tick_os;
    logic             tick_bit;
    logic [3:0]       os_phase;

    always #5 CLOCK_50 = ~CLOCK_50;

    uart_baud_gen dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .en       (en),
        .div_i    (div_i),
        .div_load (div_load),
        .align    (align),
        .tick_os  (tick_os),
        .tick_bit (tick_bit),
        .os_phase (os_phase)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the bit is a timeline of enabled cycles. m_pos counts
    // enabled cycles since the last restart (mod div*OS); m_base is the
    // oversample index the restart put us at (0, or OS/2 after align).
    int   m_div  = DEF;
    int   m_base = 0;
    int   m_pos  = 0;
    int   m_phase;
    logic m_os;
    logic m_bit;

    int cyc  = 0;
    int mark = 0;
    int first_os, first_bit, second_bit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic begin_measure();
        mark       = cyc;
        first_os   = -1;
        first_bit  = -1;
        second_bit = -1;
    endtask

    task automatic step(input logic e, input logic dl, input logic [DIV_W-1:0] di,
                        input logic al, input logic r);
        en       = e;
        div_load = dl;
        div_i    = di;
        align    = al;
        rst      = r;
        @(posedge CLOCK_50);
        m_os  = 1'b0;
        m_bit = 1'b0;
        if (r) begin
            m_div = DEF; m_base = 0; m_pos = 0;
        end else if (al) begin
            m_base = OS / 2; m_pos = 0;
        end else if (dl) begin
            m_div = int'(di); m_base = 0; m_pos = 0;
        end else if (e && m_div != 0) begin
            m_pos = (m_pos + 1) % (m_div * OS);
            if (m_pos % m_div == 0) begin
                m_os  = 1'b1;
                m_bit = ((m_base + m_pos / m_div) % OS) == 0;
            end
        end
        m_phase = (m_div == 0) ? m_base : (m_base + m_pos / m_div) % OS;
        cyc++;
        #1;
        check("tick_os", 32'(tick_os), 32'(m_os));
        check("tick_bit", 32'(tick_bit), 32'(m_bit));
        check("os_phase", 32'(os_phase), 32'(m_phase));
        if (tick_os === 1'b1 && first_os < 0) first_os = cyc - mark;
        if (tick_bit === 1'b1) begin
            if (first_bit < 0) first_bit = cyc - mark;
            else if (second_bit < 0) second_bit = cyc - mark;
        end
    endtask

    task automatic run(input int n, input logic e);
        for (int i = 0; i < n; i++) step(e, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        // 1: reset, then defaults with en held high
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        begin_measure();
        run(900, 1'b1);
        check("s1_first_os", first_os, 27);
        check("s1_first_bit", first_bit, 432);
        check("s1_second_bit", second_bit, 864);
        $display("[TB] defaults: first tick_os %0d, tick_bit %0d/%0d", first_os, first_bit, second_bit);

        // 2: load divisor 4 mid-period
        run(10, 1'b1);
        step(1'b1, 1'b1, 16'd4, 1'b0, 1'b0);
        begin_measure();
        run(140, 1'b1);
        check("s2_first_os", first_os, 4);
        check("s2_first_bit", first_bit, 64);
        check("s2_second_bit", second_bit, 128);
        $display("[TB] div_load 4: first tick_os %0d, tick_bit %0d/%0d", first_os, first_bit, second_bit);

        // 3: align with div_q=4
        run(5, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        check("s3_align_phase", 32'(os_phase), 32'd8);
        begin_measure();
        run(100, 1'b1);
        check("s3_first_bit", first_bit, 32);
        check("s3_second_bit", second_bit, 96);
        $display("[TB] align: tick_bit %0d/%0d", first_bit, second_bit);

        // 4: en low for 10 cycles mid-period with div_q=27
        step(1'b1, 1'b1, 16'd27, 1'b0, 1'b0);
        begin_measure();
        run(20, 1'b1);
        run(10, 1'b0);
        run(40, 1'b1);
        check("s4_first_os", first_os, 37);
        $display("[TB] en gap: first tick_os %0d", first_os);

        // 5: divisor 0 disables, divisor 1 ticks every cycle
        step(1'b1, 1'b1, 16'd0, 1'b0, 1'b0);
        begin_measure();
        run(50, 1'b1);
        check("s5_div0_no_tick", first_os, -1);
        step(1'b1, 1'b1, 16'd1, 1'b0, 1'b0);
        begin_measure();
        run(40, 1'b1);
        check("s5_div1_first_os", first_os, 1);
        check("s5_div1_first_bit", first_bit, 16);
        check("s5_div1_second_bit", second_bit, 32);
        $display("[TB] div 0/1: tick_os %0d, tick_bit %0d/%0d", first_os, first_bit, second_bit);

        // 6: rst together with align and div_load one cycle before a tick_bit
        step(1'b1, 1'b1, 16'd27, 1'b0, 1'b0);
        run(430, 1'b1);
        step(1'b1, 1'b1, 16'd5, 1'b1, 1'b1);
        begin_measure();
        run(440, 1'b1);
        check("s6_first_os", first_os, 27);
        check("s6_first_bit", first_bit, 432);
        $display("[TB] rst priority: tick_os %0d, tick_bit %0d", first_os, first_bit);

        // 7: randomized control traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic e, dl, al, r;
            logic [DIV_W-1:0] di;
            e  = ($urandom_range(0, 9) != 0);
            dl = ($urandom_range(0, 99) < 3);
            al = ($urandom_range(0, 99) < 2);
            r  = ($urandom_range(0, 299) == 0);
            di = DIV_W'($urandom_range(0, 6));
            step(e, dl, di, al, r);
        end
        $display("[TB] random: 3000 cycles");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
